// File: rtl/rtc_banco_lectura_if.sv
// Bus bundle between the RTC control block / display side and the read-back register bank.
// The master drives the sweep strobes and data byte; the slave (register bank) returns committed fields.
interface rtc_banco_lectura_if #(
    parameter int unsigned ERR_CNT_W = 8
);
    logic [7:0]           bus_in;
    logic                 enable_leer;
    logic                 En_seg;
    logic                 En_min;
    logic                 En_hora;
    logic                 En_dia;
    logic                 En_mes;
    logic                 En_year;
    logic                 En_cr_seg;
    logic                 En_cr_min;
    logic                 En_cr_hora;
    logic                 limpiar_alarma;

    logic [7:0]           seg;
    logic [7:0]           min;
    logic [7:0]           hora;
    logic                 pm;
    logic [7:0]           dia;
    logic [7:0]           mes;
    logic [7:0]           year;
    logic [7:0]           cr_seg;
    logic [7:0]           cr_min;
    logic [7:0]           cr_hora;
    logic                 datos_validos;
    logic                 lectura_error;
    logic [ERR_CNT_W-1:0] cont_error;
    logic                 cr_fin;

    modport master (
        output bus_in, enable_leer,
        output En_seg, En_min, En_hora, En_dia, En_mes, En_year,
        output En_cr_seg, En_cr_min, En_cr_hora, limpiar_alarma,
        input  seg, min, hora, pm, dia, mes, year, cr_seg, cr_min, cr_hora,
        input  datos_validos, lectura_error, cont_error, cr_fin
    );

    modport slave (
        input  bus_in, enable_leer,
        input  En_seg, En_min, En_hora, En_dia, En_mes, En_year,
        input  En_cr_seg, En_cr_min, En_cr_hora, limpiar_alarma,
        output seg, min, hora, pm, dia, mes, year, cr_seg, cr_min, cr_hora,
        output datos_validos, lectura_error, cont_error, cr_fin
    );
endinterface

// File: rtl/rtc_banco_lectura.sv
// RTC read-back register bank: shadows each field during a read sweep, range-checks the BCD,
// and commits all nine fields atomically only after a complete, error-free sweep.
module rtc_banco_lectura #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    rtc_banco_lectura_if.slave rif
);
    localparam int unsigned NF = 9;
    localparam int unsigned BW = 8;
    localparam int unsigned HW = 6;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_e;

    state_e               state_q, state_d;
    logic [NF-1:0]        strb;
    logic [NF-1:0]        mask_q, mask_d;
    logic                 err_q, err_d;
    logic                 sweep_start, sweep_end, commit;
    logic                 cap_ok;

    logic [BW-1:0]        sh_seg_q, sh_seg_d, sh_min_q, sh_min_d;
    logic [HW-1:0]        sh_hora_q, sh_hora_d;
    logic                 sh_pm_q, sh_pm_d;
    logic [BW-1:0]        sh_dia_q, sh_dia_d, sh_mes_q, sh_mes_d, sh_year_q, sh_year_d;
    logic [BW-1:0]        sh_cseg_q, sh_cseg_d, sh_cmin_q, sh_cmin_d, sh_chora_q, sh_chora_d;

    logic [BW-1:0]        seg_q, seg_d, min_q, min_d;
    logic [HW-1:0]        hora_q, hora_d;
    logic                 pm_q, pm_d;
    logic [BW-1:0]        dia_q, dia_d, mes_q, mes_d, year_q, year_d;
    logic [BW-1:0]        cseg_q, cseg_d, cmin_q, cmin_d, chora_q, chora_d;
    logic                 dv_q, dv_d, le_q, le_d, fin_q, fin_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    // Both nibbles decimal and value inside [lo, hi]; valid BCD compares like binary.
    function automatic logic bcd_in(input logic [BW-1:0] b, input logic [BW-1:0] lo,
                                    input logic [BW-1:0] hi);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b >= lo) && (b <= hi);
    endfunction

    assign strb = {rif.En_cr_hora, rif.En_cr_min, rif.En_cr_seg, rif.En_year, rif.En_mes,
                   rif.En_dia, rif.En_hora, rif.En_min, rif.En_seg};

    assign sweep_start = (state_q == ST_IDLE)  &&  rif.enable_leer;
    assign sweep_end   = (state_q == ST_SWEEP) && !rif.enable_leer;
    assign commit      = sweep_end && (&mask_q) && !err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            err_q      <= 1'b0;
            sh_seg_q   <= '0;
            sh_min_q   <= '0;
            sh_hora_q  <= '0;
            sh_pm_q    <= 1'b0;
            sh_dia_q   <= '0;
            sh_mes_q   <= '0;
            sh_year_q  <= '0;
            sh_cseg_q  <= '0;
            sh_cmin_q  <= '0;
            sh_chora_q <= '0;
            seg_q      <= 8'h00;
            min_q      <= 8'h00;
            hora_q     <= 6'h12;
            pm_q       <= 1'b0;
            dia_q      <= 8'h01;
            mes_q      <= 8'h01;
            year_q     <= 8'h00;
            cseg_q     <= 8'h00;
            cmin_q     <= 8'h00;
            chora_q    <= 8'h00;
            dv_q       <= 1'b0;
            le_q       <= 1'b0;
            fin_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            sh_seg_q   <= sh_seg_d;
            sh_min_q   <= sh_min_d;
            sh_hora_q  <= sh_hora_d;
            sh_pm_q    <= sh_pm_d;
            sh_dia_q   <= sh_dia_d;
            sh_mes_q   <= sh_mes_d;
            sh_year_q  <= sh_year_d;
            sh_cseg_q  <= sh_cseg_d;
            sh_cmin_q  <= sh_cmin_d;
            sh_chora_q <= sh_chora_d;
            seg_q      <= seg_d;
            min_q      <= min_d;
            hora_q     <= hora_d;
            pm_q       <= pm_d;
            dia_q      <= dia_d;
            mes_q      <= mes_d;
            year_q     <= year_d;
            cseg_q     <= cseg_d;
            cmin_q     <= cmin_d;
            chora_q    <= chora_d;
            dv_q       <= dv_d;
            le_q       <= le_d;
            fin_q      <= fin_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = rif.enable_leer ? ST_SWEEP : ST_IDLE;
        mask_d     = mask_q;
        err_d      = err_q;
        cap_ok     = 1'b1;
        sh_seg_d   = sh_seg_q;
        sh_min_d   = sh_min_q;
        sh_hora_d  = sh_hora_q;
        sh_pm_d    = sh_pm_q;
        sh_dia_d   = sh_dia_q;
        sh_mes_d   = sh_mes_q;
        sh_year_d  = sh_year_q;
        sh_cseg_d  = sh_cseg_q;
        sh_cmin_d  = sh_cmin_q;
        sh_chora_d = sh_chora_q;
        seg_d      = seg_q;
        min_d      = min_q;
        hora_d     = hora_q;
        pm_d       = pm_q;
        dia_d      = dia_q;
        mes_d      = mes_q;
        year_d     = year_q;
        cseg_d     = cseg_q;
        cmin_d     = cmin_q;
        chora_d    = chora_q;
        dv_d       = 1'b0;
        le_d       = 1'b0;
        fin_d      = fin_q;
        cnt_d      = cnt_q;

        if (sweep_start) begin
            mask_d = '0;
            err_d  = 1'b0;
        end

        // Capture: exactly one strobe writes its shadow; colliding strobes only poison the sweep.
        if (rif.enable_leer) begin
            if ($onehot(strb)) begin
                mask_d = mask_d | strb;
                case (strb)
                    9'b000000001: begin
                        sh_seg_d = rif.bus_in;
                        cap_ok   = bcd_in(rif.bus_in, 8'h00, 8'h59);
                    end
                    9'b000000010: begin
                        sh_min_d = rif.bus_in;
                        cap_ok   = bcd_in(rif.bus_in, 8'h00, 8'h59);
                    end
                    9'b000000100: begin
                        sh_hora_d = rif.bus_in[5:0];
                        sh_pm_d   = rif.bus_in[7];
                        cap_ok    = !rif.bus_in[6] &&
                                    bcd_in({2'b00, rif.bus_in[5:0]}, 8'h01, 8'h12);
                    end
                    9'b000001000: begin
                        sh_dia_d = rif.bus_in;
                        cap_ok   = bcd_in(rif.bus_in, 8'h01, 8'h31);
                    end
                    9'b000010000: begin
                        sh_mes_d = rif.bus_in;
                        cap_ok   = bcd_in(rif.bus_in, 8'h01, 8'h12);
                    end
                    9'b000100000: begin
                        sh_year_d = rif.bus_in;
                        cap_ok    = bcd_in(rif.bus_in, 8'h00, 8'h99);
                    end
                    9'b001000000: begin
                        sh_cseg_d = rif.bus_in;
                        cap_ok    = bcd_in(rif.bus_in, 8'h00, 8'h59);
                    end
                    9'b010000000: begin
                        sh_cmin_d = rif.bus_in;
                        cap_ok    = bcd_in(rif.bus_in, 8'h00, 8'h59);
                    end
                    9'b100000000: begin
                        sh_chora_d = rif.bus_in;
                        cap_ok     = bcd_in(rif.bus_in, 8'h00, 8'h23);
                    end
                    default: cap_ok = 1'b0;
                endcase
                if (!cap_ok) err_d = 1'b1;
            end else if (strb != '0) begin
                err_d = 1'b1;
            end
        end

        if (rif.limpiar_alarma) fin_d = 1'b0;

        // Decision cycle: atomic commit, or reject and count.
        if (commit) begin
            seg_d   = sh_seg_q;
            min_d   = sh_min_q;
            hora_d  = sh_hora_q;
            pm_d    = sh_pm_q;
            dia_d   = sh_dia_q;
            mes_d   = sh_mes_q;
            year_d  = sh_year_q;
            cseg_d  = sh_cseg_q;
            cmin_d  = sh_cmin_q;
            chora_d = sh_chora_q;
            dv_d    = 1'b1;
            if ({sh_chora_q, sh_cmin_q, sh_cseg_q} != '0) begin
                fin_d = 1'b0;
            end else if ({chora_q, cmin_q, cseg_q} != '0) begin
                fin_d = 1'b1;
            end
        end else if (sweep_end) begin
            le_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    assign rif.seg           = seg_q;
    assign rif.min           = min_q;
    assign rif.hora          = {2'b00, hora_q};
    assign rif.pm            = pm_q;
    assign rif.dia           = dia_q;
    assign rif.mes           = mes_q;
    assign rif.year          = year_q;
    assign rif.cr_seg        = cseg_q;
    assign rif.cr_min        = cmin_q;
    assign rif.cr_hora       = chora_q;
    assign rif.datos_validos = dv_q;
    assign rif.lectura_error = le_q;
    assign rif.cont_error    = cnt_q;
    assign rif.cr_fin        = fin_q;

endmodule

// File: tb/tb_rtc_banco_lectura.sv
// Directed bench for rtc_banco_lectura: commit, rejection, strobe collisions, chrono alarm,
// mid-sweep reset and error-counter saturation.
module tb_rtc_banco_lectura;
    localparam int unsigned ERR_CNT_W = 8;
    localparam logic [72:0] RST_OUTS = {8'h00, 8'h00, 8'h12, 1'b0, 8'h01, 8'h01, 8'h00,
                                        8'h00, 8'h00, 8'h00};

    logic clk;
    logic rst;
    logic [8:0] strb_tb;
    logic [72:0] outs;
    logic [72:0] exp_outs;
    int total;
    int bad;

    rtc_banco_lectura_if #(.ERR_CNT_W(ERR_CNT_W)) rif ();

    rtc_banco_lectura #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .rif(rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rif.En_seg     = strb_tb[0];
    assign rif.En_min     = strb_tb[1];
    assign rif.En_hora    = strb_tb[2];
    assign rif.En_dia     = strb_tb[3];
    assign rif.En_mes     = strb_tb[4];
    assign rif.En_year    = strb_tb[5];
    assign rif.En_cr_seg  = strb_tb[6];
    assign rif.En_cr_min  = strb_tb[7];
    assign rif.En_cr_hora = strb_tb[8];

    assign outs = {rif.seg, rif.min, rif.hora, rif.pm, rif.dia, rif.mes, rif.year,
                   rif.cr_seg, rif.cr_min, rif.cr_hora};

    function automatic logic [8:0][7:0] mk(input logic [7:0] s, input logic [7:0] mi,
                                           input logic [7:0] h, input logic [7:0] d,
                                           input logic [7:0] me, input logic [7:0] y,
                                           input logic [7:0] cs, input logic [7:0] cm,
                                           input logic [7:0] ch);
        logic [8:0][7:0] v;
        v[0] = s; v[1] = mi; v[2] = h; v[3] = d; v[4] = me;
        v[5] = y; v[6] = cs; v[7] = cm; v[8] = ch;
        return v;
    endfunction

    // Expected display outputs for a committed byte set (hour byte split into pm + 6-bit hour).
    function automatic logic [72:0] exp_of(input logic [8:0][7:0] v);
        return {v[0], v[1], {2'b00, v[2][5:0]}, v[2][7], v[3], v[4], v[5], v[6], v[7], v[8]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One sweep: optional pre-cycle strobe vector, then each masked field in order, then fall.
    task automatic sweep(input logic [8:0][7:0] v, input logic [8:0] m,
                         input logic [8:0] pre, input logic [7:0] pre_val);
        rif.enable_leer = 1'b1;
        step();
        if (pre != '0) begin
            rif.bus_in = pre_val;
            strb_tb    = pre;
            step();
            strb_tb    = '0;
        end
        for (int i = 0; i < 9; i++) begin
            if (m[i]) begin
                rif.bus_in = v[i];
                strb_tb    = 9'(1) << i;
                step();
                strb_tb    = '0;
            end
        end
        rif.enable_leer = 1'b0;
        step();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if (outs !== RST_OUTS) begin
            bad++; $display("FAIL reset_outs: got %h want %h", outs, RST_OUTS);
        end
        total++;
        if ({rif.datos_validos, rif.lectura_error, rif.cr_fin, rif.cont_error} !== 11'd0) begin
            bad++;
            $display("FAIL reset_flags: got dv=%b le=%b fin=%b cnt=%0d want 0", rif.datos_validos,
                     rif.lectura_error, rif.cr_fin, rif.cont_error);
        end
        exp_outs = RST_OUTS;
    endtask

    task automatic test_commit;
        logic [8:0][7:0] v;
        v = mk(8'h45, 8'h30, 8'h89, 8'h15, 8'h06, 8'h16, 8'h00, 8'h00, 8'h01);
        sweep(v, 9'h1FF, 9'h0, 8'h00);
        exp_outs = exp_of(v);
        total++;
        if (outs !== exp_outs) begin
            bad++; $display("FAIL commit_outs: got %h want %h", outs, exp_outs);
        end
        total++;
        if ({rif.datos_validos, rif.lectura_error, rif.pm, rif.hora} !== {1'b1, 1'b0, 1'b1, 8'h09}) begin
            bad++;
            $display("FAIL commit_flags: got dv=%b le=%b pm=%b hora=%h want 1 0 1 09",
                     rif.datos_validos, rif.lectura_error, rif.pm, rif.hora);
        end
        total++;
        if ({rif.cont_error, rif.cr_fin} !== {8'd0, 1'b0}) begin
            bad++; $display("FAIL commit_cnt: got cnt=%0d fin=%b want 0 0", rif.cont_error, rif.cr_fin);
        end
        step();
        total++;
        if (rif.datos_validos !== 1'b0) begin
            bad++; $display("FAIL commit_pulse_width: got dv=%b want 0", rif.datos_validos);
        end
    endtask

    task automatic test_missing;
        logic [8:0][7:0] v;
        v = mk(8'h11, 8'h22, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
        sweep(v, 9'h1DF, 9'h0, 8'h00);
        total++;
        if ({rif.lectura_error, rif.datos_validos, rif.cont_error} !== {1'b1, 1'b0, 8'd1}) begin
            bad++;
            $display("FAIL missing_flags: got le=%b dv=%b cnt=%0d want 1 0 1", rif.lectura_error,
                     rif.datos_validos, rif.cont_error);
        end
        total++;
        if (outs !== exp_outs) begin
            bad++; $display("FAIL missing_outs: got %h want %h", outs, exp_outs);
        end
        step();
        total++;
        if (rif.lectura_error !== 1'b0) begin
            bad++; $display("FAIL missing_pulse_width: got le=%b want 0", rif.lectura_error);
        end
    endtask

    task automatic test_range;
        logic [8:0][7:0] g;
        logic [8:0][7:0] v;
        int          bidx[7];
        logic [7:0]  bval[7];
        bidx = '{0, 4, 2, 3, 8, 1, 5};
        bval = '{8'h5A, 8'h13, 8'h41, 8'h00, 8'h24, 8'h60, 8'hA0};
        g = mk(8'h59, 8'h00, 8'h12, 8'h31, 8'h12, 8'h99, 8'h02, 8'h00, 8'h00);
        for (int k = 0; k < 7; k++) begin
            v = g;
            v[bidx[k]] = bval[k];
            sweep(v, 9'h1FF, 9'h0, 8'h00);
            total++;
            if ({rif.lectura_error, rif.datos_validos, rif.cont_error} !==
                {1'b1, 1'b0, 8'(2 + k)}) begin
                bad++;
                $display("FAIL range_reject[%0d]: got le=%b dv=%b cnt=%0d want 1 0 %0d", k,
                         rif.lectura_error, rif.datos_validos, rif.cont_error, 2 + k);
            end
            total++;
            if (outs !== exp_outs) begin
                bad++; $display("FAIL range_outs[%0d]: got %h want %h", k, outs, exp_outs);
            end
            step();
        end
        sweep(g, 9'h1FF, 9'h0, 8'h00);
        exp_outs = exp_of(g);
        total++;
        if ({rif.datos_validos, outs} !== {1'b1, exp_outs}) begin
            bad++;
            $display("FAIL range_boundary_commit: got dv=%b %h want 1 %h", rif.datos_validos,
                     outs, exp_outs);
        end
        step();
    endtask

    task automatic test_strobes;
        logic [8:0][7:0] g;
        g = mk(8'h33, 8'h47, 8'h81, 8'h28, 8'h02, 8'h00, 8'h00, 8'h59, 8'h23);
        sweep(g, 9'h1FF, 9'b000000011, 8'h10);
        total++;
        if ({rif.lectura_error, rif.datos_validos, rif.cont_error, outs} !==
            {1'b1, 1'b0, 8'd9, exp_outs}) begin
            bad++;
            $display("FAIL multi_strobe: got le=%b dv=%b cnt=%0d %h want 1 0 9 %h",
                     rif.lectura_error, rif.datos_validos, rif.cont_error, outs, exp_outs);
        end
        step();
        sweep(g, 9'h1FF, 9'b000000001, 8'h6A);
        total++;
        if ({rif.lectura_error, rif.cont_error, outs} !== {1'b1, 8'd10, exp_outs}) begin
            bad++;
            $display("FAIL sticky_err: got le=%b cnt=%0d %h want 1 10 %h", rif.lectura_error,
                     rif.cont_error, outs, exp_outs);
        end
        step();
        rif.bus_in = 8'h77;
        strb_tb    = 9'h1FF;
        step();
        step();
        strb_tb    = '0;
        total++;
        if ({rif.datos_validos, rif.lectura_error, outs} !== {2'b00, exp_outs}) begin
            bad++;
            $display("FAIL idle_strobes: got dv=%b le=%b %h want 0 0 %h", rif.datos_validos,
                     rif.lectura_error, outs, exp_outs);
        end
        sweep(g, 9'h1FF, 9'b000000001, 8'h11);
        exp_outs = exp_of(g);
        total++;
        if ({rif.datos_validos, rif.cont_error, outs} !== {1'b1, 8'd10, exp_outs}) begin
            bad++;
            $display("FAIL last_wins_commit: got dv=%b cnt=%0d %h want 1 10 %h",
                     rif.datos_validos, rif.cont_error, outs, exp_outs);
        end
        step();
    endtask

    task automatic test_chrono;
        logic [8:0][7:0] v;
        logic [7:0] cs[8];
        logic [7:0] cm[8];
        logic       op_clr[8];
        logic       lim[8];
        logic       efin[8];
        cs     = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00};
        cm     = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        op_clr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lim    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        efin   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) begin
            if (op_clr[k]) begin
                rif.limpiar_alarma = 1'b1;
                step();
                rif.limpiar_alarma = 1'b0;
            end else begin
                v = mk(8'h10, 8'h20, 8'h05, 8'h07, 8'h08, 8'h24, cs[k], cm[k], 8'h00);
                rif.limpiar_alarma = lim[k];
                sweep(v, 9'h1FF, 9'h0, 8'h00);
                rif.limpiar_alarma = 1'b0;
                exp_outs = exp_of(v);
                total++;
                if ({rif.datos_validos, outs} !== {1'b1, exp_outs}) begin
                    bad++;
                    $display("FAIL chrono_commit[%0d]: got dv=%b %h want 1 %h", k,
                             rif.datos_validos, outs, exp_outs);
                end
            end
            total++;
            if (rif.cr_fin !== efin[k]) begin
                bad++; $display("FAIL cr_fin[%0d]: got %b want %b", k, rif.cr_fin, efin[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid;
        rif.enable_leer = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            rif.bus_in = 8'h02;
            strb_tb    = 9'(1) << i;
            step();
        end
        strb_tb = '0;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        total++;
        if (outs !== RST_OUTS) begin
            bad++; $display("FAIL midreset_outs: got %h want %h", outs, RST_OUTS);
        end
        total++;
        if ({rif.datos_validos, rif.lectura_error, rif.cr_fin, rif.cont_error} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_flags: got dv=%b le=%b fin=%b cnt=%0d want 0",
                     rif.datos_validos, rif.lectura_error, rif.cr_fin, rif.cont_error);
        end
        rif.enable_leer = 1'b0;
        step();
        step();
        total++;
        if ({rif.datos_validos, rif.lectura_error, rif.cont_error} !== 10'd0) begin
            bad++;
            $display("FAIL midreset_no_pulse: got dv=%b le=%b cnt=%0d want 0 0 0",
                     rif.datos_validos, rif.lectura_error, rif.cont_error);
        end
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 255; k++) begin
            rif.enable_leer = 1'b1;
            step();
            rif.enable_leer = 1'b0;
            step();
        end
        total++;
        if ({rif.lectura_error, rif.cont_error} !== {1'b1, 8'd255}) begin
            bad++;
            $display("FAIL count_255: got le=%b cnt=%0d want 1 255", rif.lectura_error,
                     rif.cont_error);
        end
        rif.enable_leer = 1'b1;
        step();
        rif.enable_leer = 1'b0;
        step();
        total++;
        if ({rif.lectura_error, rif.datos_validos, rif.cont_error, outs} !==
            {1'b1, 1'b0, 8'd255, RST_OUTS}) begin
            bad++;
            $display("FAIL count_saturate: got le=%b dv=%b cnt=%0d %h want 1 0 255 %h",
                     rif.lectura_error, rif.datos_validos, rif.cont_error, outs, RST_OUTS);
        end
        step();
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        rst                = 1'b1;
        strb_tb            = '0;
        rif.bus_in         = 8'h00;
        rif.enable_leer    = 1'b0;
        rif.limpiar_alarma = 1'b0;
        exp_outs           = RST_OUTS;
        test_reset();
        test_commit();
        test_missing();
        test_range();
        test_strobes();
        test_chrono();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
